// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, issues one ROM fetch at a time and feeds decode.
// Latency: a zero-wait ROM gives one instruction per cycle. On stall, one word parks in a skid entry and ce drops.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic        ce,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        skid_full_q, skid_full_d;
  logic        out_free;

  assign out_free = !out_vld_q || !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_vld_d   = out_vld_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    skid_full_d = skid_full_q;

    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (rom_ack) begin
          if (out_free) begin
            out_pc_d   = pc_q;
            out_inst_d = rom_data;
            out_vld_d  = 1'b1;
          end else begin
            skid_pc_d   = pc_q;
            skid_inst_d = rom_data;
            skid_full_d = 1'b1;
            state_d     = HOLD;
          end
          pc_d = pc_q + 32'd4;
        end else if (out_free) begin
          out_vld_d = 1'b0;
        end
      end
      HOLD: begin
        // Decode takes the output word on this edge, so the skid word slides in behind it.
        if (!stall) begin
          out_pc_d    = skid_pc_q;
          out_inst_d  = skid_inst_q;
          out_vld_d   = 1'b1;
          skid_full_d = 1'b0;
          state_d     = REQ;
        end
      end
      default: state_d = BOOT;
    endcase

    // A redirect overrides everything above, including a same-cycle ack.
    if (branch_flag && state_q != BOOT) begin
      out_vld_d   = 1'b0;
      skid_full_d = 1'b0;
      pc_d        = branch_target & 32'hFFFF_FFFC;
      state_d     = REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      out_pc_q    <= 32'h0;
      out_inst_q  <= 32'h0;
      out_vld_q   <= 1'b0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
      skid_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_vld_q   <= out_vld_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign pc       = pc_q;
  assign ce       = (state_q == REQ);
  assign if_pc    = out_pc_q;
  assign if_inst  = out_inst_q;
  assign if_valid = out_vld_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed timing scenarios plus a randomized run checked
// against an address-stream scoreboard (consumed words must follow PC order from the last redirect).
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst, rst2;
  logic [31:0] pc, pc2;
  logic        ce, ce2;
  logic        rom_ack, rom_ack2;
  logic [31:0] rom_data, rom_data2;
  logic        stall, branch_flag;
  logic [31:0] branch_target;
  logic [31:0] if_pc, if_inst, if_pc2, if_inst2;
  logic        if_valid, if_valid2;
  logic        ack_gate;
  logic        zero1;
  logic [31:0] zero32;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign rom_ack   = ce & ack_gate;
  assign rom_data  = rom_fn(pc);
  assign rom_ack2  = ce2;
  assign rom_data2 = rom_fn(pc2);

  if_fetch_ctrl #(.RESET_PC(32'h00000000)) u_dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .rom_ack(rom_ack), .rom_data(rom_data),
    .stall(stall), .branch_flag(branch_flag), .branch_target(branch_target),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFFFFF8)) u_wrap (
    .clk(clk), .rst(rst2), .pc(pc2), .ce(ce2), .rom_ack(rom_ack2), .rom_data(rom_data2),
    .stall(zero1), .branch_flag(zero1), .branch_target(zero32),
    .if_pc(if_pc2), .if_inst(if_inst2), .if_valid(if_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    #1;
    checks++; if (pc !== 32'h0)       begin failures++; $display("FAIL reset_pc act=%h exp=%h", pc, 32'h0); end
    checks++; if (ce !== 1'b0)        begin failures++; $display("FAIL reset_ce act=%b exp=0", ce); end
    checks++; if (if_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid act=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'h0)    begin failures++; $display("FAIL reset_if_pc act=%h exp=0", if_pc); end
    checks++; if (if_inst !== 32'h0)  begin failures++; $display("FAIL reset_if_inst act=%h exp=0", if_inst); end
    checks++; if (pc2 !== 32'hFFFFFFF8) begin failures++; $display("FAIL reset_pc2 act=%h exp=FFFFFFF8", pc2); end
  endtask

  task automatic test_stream;
    @(negedge clk);
    rst = 1'b0; ack_gate = 1'b1;
    checks++; if (ce !== 1'b0) begin failures++; $display("FAIL boot_ce act=%b exp=0", ce); end
    @(negedge clk);
    checks++; if (ce !== 1'b1 || if_valid !== 1'b0 || pc !== 32'h0)
      begin failures++; $display("FAIL after_e0 ce=%b valid=%b pc=%h exp ce=1 valid=0 pc=0", ce, if_valid, pc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_inst !== rom_fn(32'(i * 4)) || ce !== 1'b1)
        begin failures++; $display("FAIL stream_%0d valid=%b if_pc=%h inst=%h ce=%b exp if_pc=%h", i, if_valid, if_pc, if_inst, ce, 32'(i * 4)); end
    end
  endtask

  task automatic test_stall_skid;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== rom_fn(32'h8) || ce !== 1'b0)
        begin failures++; $display("FAIL stall_hold_%0d valid=%b if_pc=%h ce=%b exp if_pc=8 ce=0", i, if_valid, if_pc, ce); end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hC || if_inst !== rom_fn(32'hC) || ce !== 1'b1 || pc !== 32'h10)
      begin failures++; $display("FAIL skid_release valid=%b if_pc=%h ce=%b pc=%h exp if_pc=C ce=1 pc=10", if_valid, if_pc, ce, pc); end
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_inst !== rom_fn(32'h10))
      begin failures++; $display("FAIL after_skid valid=%b if_pc=%h exp if_pc=10", if_valid, if_pc); end
  endtask

  task automatic test_branch;
    stall = 1'b1;
    @(negedge clk);
    checks++; if (ce !== 1'b0 || if_pc !== 32'h10)
      begin failures++; $display("FAIL pre_branch_hold ce=%b if_pc=%h exp ce=0 if_pc=10", ce, if_pc); end
    branch_flag = 1'b1; branch_target = 32'h00000103;
    @(negedge clk);
    branch_flag = 1'b0; stall = 1'b0;
    checks++; if (if_valid !== 1'b0 || pc !== 32'h100 || ce !== 1'b1)
      begin failures++; $display("FAIL branch_flush valid=%b pc=%h ce=%b exp valid=0 pc=100 ce=1", if_valid, pc, ce); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== rom_fn(32'h100))
      begin failures++; $display("FAIL branch_first valid=%b if_pc=%h exp if_pc=100", if_valid, if_pc); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104)
      begin failures++; $display("FAIL branch_second valid=%b if_pc=%h exp if_pc=104", if_valid, if_pc); end
  endtask

  task automatic test_wait_states;
    logic [31:0] prev_pc, last_vpc;
    logic        prev_ack;
    prev_pc = '0; last_vpc = '0; prev_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        last_vpc = if_pc;
      end else begin
        if (!prev_ack) begin
          checks++; if (pc !== prev_pc || ce !== 1'b1)
            begin failures++; $display("FAIL wait_stable_%0d pc=%h ce=%b exp pc=%h ce=1", i, pc, ce, prev_pc); end
        end
        checks++; if (if_valid !== prev_ack)
          begin failures++; $display("FAIL wait_pulse_%0d valid=%b exp=%b", i, if_valid, prev_ack); end
        if (prev_ack) begin
          checks++; if (if_pc !== last_vpc + 32'd4 || if_inst !== rom_fn(last_vpc + 32'd4))
            begin failures++; $display("FAIL wait_addr_%0d if_pc=%h exp=%h", i, if_pc, last_vpc + 32'd4); end
          last_vpc = last_vpc + 32'd4;
        end
      end
      prev_pc  = pc;
      ack_gate = (i % 3 == 2);
      prev_ack = ack_gate;
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hFFFFFFF8; exp_seq[1] = 32'hFFFFFFFC; exp_seq[2] = 32'h00000000;
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    checks++; if (ce2 !== 1'b1 || if_valid2 !== 1'b0)
      begin failures++; $display("FAIL wrap_e0 ce=%b valid=%b exp ce=1 valid=0", ce2, if_valid2); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (if_valid2 !== 1'b1 || if_pc2 !== exp_seq[i] || if_inst2 !== rom_fn(exp_seq[i]))
        begin failures++; $display("FAIL wrap_%0d valid=%b if_pc=%h exp=%h", i, if_valid2, if_pc2, exp_seq[i]); end
    end
    checks++; if (pc2 !== 32'h4)
      begin failures++; $display("FAIL wrap_pc act=%h exp=4", pc2); end
  endtask

  task automatic test_async_reset;
    ack_gate = 1'b1;
    @(negedge clk);
    checks++; if (ce !== 1'b1)
      begin failures++; $display("FAIL pre_reset_ce act=%b exp=1", ce); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ce !== 1'b0 || if_valid !== 1'b0 || pc !== 32'h0 || if_pc !== 32'h0 || if_inst !== 32'h0)
      begin failures++; $display("FAIL async_reset ce=%b valid=%b pc=%h if_pc=%h exp all 0", ce, if_valid, pc, if_pc); end
  endtask

  task automatic test_random;
    logic [31:0] exp_next, prev_pc;
    logic        chk_stable, ack_now;
    int          consumed;
    exp_next = 32'h0; prev_pc = '0; chk_stable = 1'b0; consumed = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      checks++; if (pc[1:0] !== 2'b00)
        begin failures++; $display("FAIL rnd_align cyc=%0d pc=%h", cyc, pc); end
      if (chk_stable) begin
        checks++; if (pc !== prev_pc || ce !== 1'b1)
          begin failures++; $display("FAIL rnd_stable cyc=%0d pc=%h ce=%b exp pc=%h ce=1", cyc, pc, ce, prev_pc); end
      end
      stall         = ($urandom % 3 == 0);
      branch_flag   = (cyc > 0) && ($urandom % 40 == 0);
      branch_target = $urandom;
      ack_gate      = $urandom % 2;
      ack_now       = ce && ack_gate;
      // Reference: decode sees addresses in strict +4 order from the last redirect.
      if (branch_flag) begin
        exp_next = branch_target & 32'hFFFF_FFFC;
      end else if (if_valid && !stall) begin
        checks++; if (if_pc !== exp_next || if_inst !== rom_fn(exp_next))
          begin failures++; $display("FAIL rnd_stream cyc=%0d if_pc=%h inst=%h exp if_pc=%h inst=%h", cyc, if_pc, if_inst, exp_next, rom_fn(exp_next)); end
        exp_next = exp_next + 32'd4;
        consumed++;
      end
      chk_stable = ce && !ack_now && !branch_flag;
      prev_pc    = pc;
    end
    branch_flag = 1'b0; stall = 1'b0;
    checks++; if (consumed < 300)
      begin failures++; $display("FAIL rnd_progress consumed=%0d exp>=300", consumed); end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    stall = 1'b0; branch_flag = 1'b0; branch_target = '0;
    ack_gate = 1'b0; zero1 = 1'b0; zero32 = '0;
    test_reset;
    test_stream;
    test_stall_skid;
    test_branch;
    test_wait_states;
    test_wrap;
    test_async_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller that owns the program counter and sequences instruction-ROM reads for the IF stage. It issues one fetch at a time over a ce/ack handshake and buffers returned words so a stalled decode stage never loses an instruction. It also redirects the PC on a branch from a later stage. The block drives the IF/ID boundary: pc and ce go to instruction memory, and if_pc/if_inst/if_valid go to decode.

## Interface
- RESET_PC, default 32'h00000000: PC loaded on reset.
- clk  in  1: system clock; all state changes on its rising edge.
- rst  in  1: reset, asynchronous, active-high (`RstEnable` = 1'b1).
- pc  out  32: fetch address to instruction ROM; word aligned, bits [1:0] always 0.
- ce  out  1: ROM chip enable / fetch request (`ChipEnable` = 1).
- rom_ack  in  1: ROM data valid this cycle; sampled only while ce=1.
- rom_data  in  32: instruction word; valid when rom_ack=1.
- stall  in  1: decode cannot accept if_inst this cycle.
- branch_flag  in  1: redirect request from the execute stage.
- branch_target  in  32: redirect address; bits [1:0] ignored and forced to 0.
- if_pc  out  32: address of the instruction in if_inst.
- if_inst  out  32: instruction presented to decode.
- if_valid  out  1: if_inst/if_pc are valid.

## Operation
- Registered state: state, pc, output register (if_pc, if_inst, if_valid), and a one-entry skid buffer (skid_pc, skid_inst, skid_full).
- Accept rule: decode consumes the output register on an edge where if_valid=1 and stall=0. The output register may be loaded when `out_free = !if_valid || !stall`.
- States:
  - BOOT: entered on reset. ce=0. On the next edge, go to REQ.
  - REQ: ce=1 and pc is held stable until rom_ack.
    - rom_ack=1 and out_free: load the output register with (pc, rom_data), set if_valid=1, set pc<=pc+4, stay in REQ.
    - rom_ack=1 and !out_free: write (pc, rom_data) into the skid buffer, set pc<=pc+4, go to HOLD.
    - rom_ack=0: if out_free, clear if_valid. Otherwise hold the output register.
  - HOLD: ce=0. When stall=0, move the skid buffer to the output register, clear skid_full, and go to REQ.
- Branch (branch_flag=1) has top priority in every state except BOOT, where it is ignored:
  - if_valid<=0 and skid_full<=0.
  - pc<={branch_target[31:2],2'b00}.
  - state<=REQ.
  - Any rom_ack in the same cycle is discarded.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000. There is no trap.
- At most one fetch is outstanding, and the skid buffer holds at most one word. Instructions are never dropped or duplicated except when flushed by a branch.

## Timing
- Reset values (asynchronous, immediate): state=BOOT, pc=RESET_PC, ce=0, if_valid=0, if_pc=0, if_inst=0, skid_full=0.
- Reset asserted mid-fetch aborts the fetch immediately. Any in-flight ack is ignored.
- Startup, with edge e0 being the first edge after rst deasserts:
  - ce=1 after e0.
  - With a zero-wait ROM (rom_ack=1 whenever ce=1), the first if_valid=1 appears after e1, with if_pc=RESET_PC.
- Throughput: one instruction per cycle with a zero-wait ROM and stall=0.
- Wait states: with an N-wait-state ROM, there is one instruction per N+1 cycles. pc and ce stay stable during the wait.
- Stall:
  - The output register and skid buffer hold their values for as long as stall=1.
  - ce drops the cycle after the skid buffer fills.
  - Once stall deasserts, the first new ROM request is issued the following cycle.
- Branch-to-valid latency, zero-wait ROM: if branch_flag is sampled at edge k, if_valid=1 with if_pc=target appears after edge k+1. if_valid=0 for the cycle between.
- Simultaneous branch_flag and stall: the branch wins and the stall is irrelevant, because the output register is flushed.

## Test plan
- Reset and stream: zero-wait ROM, RESET_PC=0 → if_pc sequence 0,4,8,C on consecutive cycles; ce=0 only in the cycle after reset release.
- Stall with skid: stall=1 for 3 cycles while if_pc=8 → if_inst and if_pc hold at 8, skid holds C, ce=0. After release, the sequence is 8 then C then 10 with no gaps or duplicates.
- Wait states: rom_ack asserted every 3rd cycle → pc is stable while waiting, if_valid pulses once per ack, and addresses increase by 4.
- Branch: branch_flag=1 with target 32'h00000103 while the skid buffer is full and stall=1 → the buffer is flushed, pc=32'h00000100, the next valid is if_pc=100, and the stalled instruction never appears.
- Wrap: RESET_PC=32'hFFFFFFF8 → if_pc FFFFFFF8, FFFFFFFC, 00000000.
- Asynchronous reset mid-fetch: assert rst between edges during REQ → ce=0, if_valid=0 and pc=RESET_PC immediately, without waiting for a clock edge.
